// File: rtl/uart_tx_if.sv
// uart_tx_if - byte-output port between the CPU core and the UART transmitter.
//
// Signals:
//   uart_en      core -> uart  single-cycle byte-write strobe
//   uart_tx_data core -> uart  byte to send, valid while uart_en is high
//   busy         uart -> core  FIFO non-empty or a frame on the line
//   fifo_full    uart -> core  FIFO holds FIFO_DEPTH entries
//   overflow     uart -> core  sticky: a strobe was dropped on a full FIFO
//
// Modports: master = core side, slave = transmitter side.
interface uart_tx_if;
  logic       uart_en;
  logic [7:0] uart_tx_data;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  modport master (output uart_en, uart_tx_data, input busy, fifo_full, overflow);
  modport slave  (input uart_en, uart_tx_data, output busy, fifo_full, overflow);
endinterface

// File: rtl/uart_tx.sv
// uart_tx - buffered 8N1 serial transmitter fed by the core's byte strobe.
//
// The core has no backpressure, so bytes land in a FIFO_DEPTH-entry circular
// buffer and are serialized LSB-first at CLKS_PER_BIT clocks per bit.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   FIFO_DEPTH    byte entries (power of 2, >= 2)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts the frame, empties the FIFO
//   bus    uart_tx_if.slave (uart_en, uart_tx_data, busy, fifo_full, overflow)
//   tx     registered serial line, idles high
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data bits)
//                      is sent between the last data bit and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          empty, full, push, pop;
  logic [7:0]    rd_data;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign push    = bus.uart_en && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.uart_tx_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (bus.uart_en && !push) overflow_q <= 1'b1;
    end
  end

  // ---------------- serializer FSM ----------------
  state_t        state_q, state_nxt;
  logic [BW-1:0] baud_q, baud_nxt;
  logic [2:0]    bit_q, bit_nxt;
  logic [7:0]    shift_q, shift_nxt;
  logic          tx_nxt;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_nxt;
`endif

  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      shift_q <= shift_nxt;
      tx      <= tx_nxt;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    baud_nxt  = bit_end ? '0 : baud_q + BW'(1);
    bit_nxt   = bit_q;
    shift_nxt = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_nxt   = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = rd_data;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^rd_data;
`endif
          state_nxt = START;
        end
      end
      START: if (bit_end) begin
        bit_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: if (bit_end) begin
        shift_nxt = {1'b0, shift_q[7:1]};
        bit_nxt   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_nxt = STOP;
`endif
      STOP: if (bit_end) begin
        // Chain straight into the next start bit when more bytes wait.
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = rd_data;
`ifdef UART_TX_PARITY_EN
          par_nxt   = ^rd_data;
`endif
          state_nxt = START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is registered, so it is driven from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.busy      = (state_q != IDLE) || !empty;
  assign bus.fifo_full = full;
  assign bus.overflow  = overflow_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that consumes the CPU core's byte-output strobe (`uart_en` / `uart_tx_data`) and drives an 8N1 asynchronous serial line. The core writes a byte with a single-cycle strobe and has no backpressure input, so the block buffers bytes in a small FIFO and serializes them LSB-first at a fixed baud divisor. It sits between the core's UART output ports and the board TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Minimum value 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of 2, at least 2.

Ports:
- `clk`, input, 1 bit: clock, rising-edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `uart_en`, input, 1 bit: byte-write strobe, one byte per high cycle.
- `uart_tx_data`, input, 8 bits: byte to send, sampled when `uart_en` is 1.
- `tx`, output, 1 bit: serial line, registered, idles high.
- `busy`, output, 1 bit: high when the FIFO is non-empty or a frame is in progress.
- `fifo_full`, output, 1 bit: FIFO holds `FIFO_DEPTH` entries.
- `overflow`, output, 1 bit: sticky flag, set when a strobe is dropped because the FIFO is full.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers and a count of width $clog2(FIFO_DEPTH+1); pointers wrap modulo `FIFO_DEPTH`.
  - Push: on any edge with `uart_en`=1 and the FIFO not full.
  - Pop: on an edge where the FSM loads a byte.
  - Push and pop on the same edge: both happen and the count is unchanged. This includes the full case, where the push is accepted.
  - Push while full with no pop: the byte is dropped and `overflow` is set to 1. It stays 1 until reset.
- **FSM states:** IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the 8-bit shift register, clear the baud counter, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles, then shift right and increment the bit index. After bit 7, go to PARITY if enabled, otherwise STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Counters:** the baud counter counts 0..`CLKS_PER_BIT`-1 and wraps at each bit boundary. The bit index is 3 bits.
- **`busy`:** equals (state != IDLE) OR (count != 0).
- **`fifo_full`:** equals (count == `FIFO_DEPTH`).

## Timing
- **Reset values:** `tx`=1, `busy`=0, `fifo_full`=0, `overflow`=0; state IDLE, FIFO empty, counters 0.
- **Reset assertion mid-frame:** `tx` returns to 1 asynchronously. The frame is aborted and FIFO contents are discarded.
- **Latency:** a strobe sampled at edge E0 makes the FIFO non-empty. At edge E1 the FSM pops and `tx` falls, so the start bit begins one cycle after the strobe edge.
- **Frame length:** 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- **Back-to-back frames:** the next start bit directly follows the last stop-bit cycle.
- **Strobe rate:** `uart_en` may be high on consecutive cycles; each high cycle is one byte.
- **Flag timing:** `fifo_full` and `overflow` update on the edge that causes the condition.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and inserted between DATA and STOP. `tx` carries the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles. The frame is 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state; 8N1 frame of 10 bits.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 unless stated otherwise.
- **Single byte:** one strobe with 0xA5.
  - `tx` goes low at E1 for 4 cycles, then data 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles.
  - `busy` drops exactly 40 cycles after E1.
- **Back-to-back:** strobes with 0x55 then 0x0F on consecutive cycles.
  - Two frames totalling 80 cycles, with no high gap between the first stop bit and the second start bit.
- **Overflow:** six strobes on consecutive cycles with 0x01..0x06.
  - `fifo_full` rises after the fifth strobe; the sixth byte (0x06) is dropped and `overflow`=1.
  - Frames 0x01..0x05 are transmitted in order and `overflow` stays 1 afterwards.
- **Full with simultaneous pop:** fill the FIFO during a frame, then strobe on the final STOP cycle.
  - The byte is accepted, count stays 4, and `overflow` stays 0.
- **Reset mid-frame:** assert `reset` low during DATA bit 3 with two bytes queued.
  - `tx`=1 and `busy`=0 immediately.
  - After release, `tx` stays high until a new strobe arrives.
- **Parity (macro defined):** send 0x07.
  - The parity bit is 1, the stop bit follows, and the frame is 44 cycles.
